keypad_encoder: RTL and testbench



---
 rtl/keypad_pkg.sv | 43 ++++
 rtl/keypad_encoder_if.sv | 27 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/keypad_encoder.sv | 130 +++++++++++++
 tb/tb_keypad_encoder.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types and combinational helpers for the keypad encoder.
// Key vectors are one bit per digit, bit i meaning digit i.
package keypad_pkg;

  localparam int unsigned KEY_COUNT = 10;
  localparam int unsigned CODE_W    = 4;

  typedef logic [1:0] state_e;
  localparam state_e StIdle     = 2'd0;
  localparam state_e StDebounce = 2'd1;
  localparam state_e StHeld     = 2'd2;
  localparam state_e StRelease  = 2'd3;

  function automatic logic [CODE_W-1:0] key_popcount(input logic [KEY_COUNT-1:0] k);
    logic [CODE_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < KEY_COUNT; i++) begin
      cnt = cnt + CODE_W'(k[i]);
    end
    return cnt;
  endfunction

  function automatic logic is_single(input logic [KEY_COUNT-1:0] k);
    return key_popcount(k) == CODE_W'(1);
  endfunction

  function automatic logic is_multi(input logic [KEY_COUNT-1:0] k);
    return key_popcount(k) > CODE_W'(1);
  endfunction

  // Only meaningful for a one-hot input; always yields 0..KEY_COUNT-1.
  function automatic logic [CODE_W-1:0] onehot_to_idx(input logic [KEY_COUNT-1:0] k);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < KEY_COUNT; i++) begin
      if (k[i]) begin
        idx = CODE_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_encoder_if.sv
// Key lines in, encoded key events out.
interface keypad_encoder_if;
  import keypad_pkg::*;

  logic [KEY_COUNT-1:0] keys;
  logic [CODE_W-1:0]    key_code;
  logic                 key_down;
  logic                 key_strobe;
  logic                 multi_err;

  modport master (
    output keys,
    input  key_code,
    input  key_down,
    input  key_strobe,
    input  multi_err
  );

  modport slave (
    input  keys,
    output key_code,
    output key_down,
    output key_strobe,
    output multi_err
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
module sync_2ff #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_encoder.sv
// Debounces the 10-key keypad and reports one accepted digit at a time
// as a BCD code with a held level and a one-cycle acceptance strobe.
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned RELEASE_CYCLES  = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  keypad_encoder_if.slave   bus
);

  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DebLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RelLast = CNT_W'(RELEASE_CYCLES - 1);

  logic [KEY_COUNT-1:0] ks;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] cand_q, cand_d;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic              key_down_q, key_down_d;
  logic              key_strobe_q, key_strobe_d;
  logic              multi_err_q, multi_err_d;

  logic              ks_single;
  logic [CODE_W-1:0] ks_idx;

  sync_2ff #(
    .WIDTH (KEY_COUNT)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.keys),
    .q_o   (ks)
  );

  assign ks_single = is_single(ks);
  assign ks_idx    = onehot_to_idx(ks);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cand_d       = cand_q;
    key_code_d   = key_code_q;
    key_down_d   = key_down_q;
    key_strobe_d = 1'b0;
    // Ambiguity is only reported while no key is owned.
    multi_err_d  = is_multi(ks) && ((state_q == StIdle) || (state_q == StDebounce));

    case (state_q)
      StIdle: begin
        if (ks_single) begin
          cand_d  = ks_idx;
          cnt_d   = CntOne;
          state_d = StDebounce;
        end
      end
      StDebounce: begin
        if (ks_single && (ks_idx == cand_q)) begin
          if (cnt_q == DebLast) begin
            state_d      = StHeld;
            cnt_d        = '0;
            key_strobe_d = 1'b1;
            key_down_d   = 1'b1;
            key_code_d   = cand_q;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end else begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      StHeld: begin
        // Other keys pressed alongside the owned key are ignored.
        if (!ks[cand_q]) begin
          state_d = StRelease;
          cnt_d   = CntOne;
        end
      end
      StRelease: begin
        if (ks == '0) begin
          if (cnt_q == RelLast) begin
            state_d    = StIdle;
            cnt_d      = '0;
            key_down_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end else begin
          cnt_d = CntOne;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      cand_q       <= '0;
      key_code_q   <= '0;
      key_down_q   <= 1'b0;
      key_strobe_q <= 1'b0;
      multi_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cand_q       <= cand_d;
      key_code_q   <= key_code_d;
      key_down_q   <= key_down_d;
      key_strobe_q <= key_strobe_d;
      multi_err_q  <= multi_err_d;
    end
  end

  assign bus.key_code   = key_code_q;
  assign bus.key_down   = key_down_q;
  assign bus.key_strobe = key_strobe_q;
  assign bus.multi_err  = multi_err_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder with a timestamp-based reference model.
module tb_keypad_encoder;
  import keypad_pkg::*;

  localparam int DEB = 4;
  localparam int REL = 4;

  logic clk;
  logic rst_n;
  keypad_encoder_if bus ();

  keypad_encoder #(
    .DEBOUNCE_CYCLES (DEB),
    .RELEASE_CYCLES  (REL),
    .CNT_W           (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int strobes     = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: raw keys reach the decision logic two edges late; a
  // candidate is accepted DEB-1 edges after it first appears unchanged, and
  // the held level drops REL-1 edges after the last edge that saw any key
  // (or saw the owned key vanish), provided every edge since saw none.
  logic [9:0] p0, p1;
  int  edge_n;
  bit  cand_valid;
  logic [9:0] cand;
  int  cand_edge;
  bit  releasing;
  int  restart_edge;
  bit  m_down, m_strobe, m_err;
  int  m_code;

  function automatic int idx_of(input logic [9:0] k);
    int r;
    r = 0;
    for (int i = 0; i < 10; i++) if (k[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    p0 = '0; p1 = '0; edge_n = 0;
    cand_valid = 0; cand = '0; cand_edge = 0;
    releasing = 0; restart_edge = 0;
    m_down = 0; m_strobe = 0; m_err = 0; m_code = 0;
  endtask

  task automatic model_step();
    logic [9:0] ks;
    ks = p1;
    p1 = p0;
    p0 = bus.keys;
    m_strobe = 0;
    m_err = !m_down && ($countones(ks) > 1);
    if (!m_down) begin
      if (cand_valid && ks == cand) begin
        if (edge_n - cand_edge == DEB - 1) begin
          m_down = 1; m_strobe = 1; m_code = idx_of(cand);
          cand_valid = 0; releasing = 0;
        end
      end else if (cand_valid) begin
        cand_valid = 0;
      end else if ($countones(ks) == 1) begin
        cand_valid = 1; cand = ks; cand_edge = edge_n;
      end
    end else if (!releasing) begin
      if (!ks[m_code]) begin
        releasing = 1; restart_edge = edge_n;
      end
    end else if (ks != '0) begin
      restart_edge = edge_n;
    end else if (edge_n - restart_edge == REL - 1) begin
      m_down = 0; releasing = 0;
    end
    edge_n++;
  endtask

  initial model_reset();

  always begin
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    chk("model key_code",   int'(bus.key_code),   m_code);
    chk("model key_down",   int'(bus.key_down),   int'(m_down));
    chk("model key_strobe", int'(bus.key_strobe), int'(m_strobe));
    chk("model multi_err",  int'(bus.multi_err),  int'(m_err));
    if (bus.key_strobe) strobes++;
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_keys(input logic [9:0] k);
    @(negedge clk);
    bus.keys = k;
  endtask

  int s0;

  initial begin
    rst_n = 1'b0;
    bus.keys = '0;
    edges(3);
    chk("reset key_code",   int'(bus.key_code),   0);
    chk("reset key_down",   int'(bus.key_down),   0);
    chk("reset key_strobe", int'(bus.key_strobe), 0);
    chk("reset multi_err",  int'(bus.multi_err),  0);
    @(negedge clk);
    rst_n = 1'b1;
    edges(2);

    // Clean press of digit 3.
    s0 = strobes;
    set_keys(10'b0000001000);
    edges(5);
    chk("clean strobe e5", int'(bus.key_strobe), 0);
    chk("clean down e5",   int'(bus.key_down),   0);
    edges(1);
    chk("clean strobe e6", int'(bus.key_strobe), 1);
    chk("clean code e6",   int'(bus.key_code),   3);
    chk("clean down e6",   int'(bus.key_down),   1);
    edges(1);
    chk("clean strobe e7", int'(bus.key_strobe), 0);
    edges(13);
    set_keys('0);
    edges(5);
    chk("clean down rel e5", int'(bus.key_down), 1);
    edges(1);
    chk("clean down rel e6", int'(bus.key_down), 0);
    chk("clean code kept",   int'(bus.key_code), 3);
    chk("clean strobe count", strobes - s0, 1);
    edges(2);

    // Digit 7 bouncing 2 high / 1 low three times, then steady.
    s0 = strobes;
    for (int i = 0; i < 3; i++) begin
      set_keys(10'b0010000000);
      @(negedge clk);
      set_keys('0);
    end
    set_keys(10'b0010000000);
    edges(5);
    chk("bounce strobe e5", int'(bus.key_strobe), 0);
    edges(1);
    chk("bounce strobe e6", int'(bus.key_strobe), 1);
    chk("bounce code",      int'(bus.key_code),   7);
    chk("bounce strobe count", strobes - s0, 1);
    edges(4);
    set_keys('0);
    edges(8);

    // Digits 1 and 2 together.
    s0 = strobes;
    set_keys(10'b0000000110);
    edges(2);
    chk("multi err e2", int'(bus.multi_err), 0);
    edges(1);
    chk("multi err e3", int'(bus.multi_err), 1);
    edges(7);
    chk("multi err e10", int'(bus.multi_err), 1);
    chk("multi down",    int'(bus.key_down),  0);
    set_keys('0);
    edges(4);
    chk("multi err cleared",   int'(bus.multi_err), 0);
    chk("multi strobe count",  strobes - s0, 0);

    // Digit 5 held, digit 9 added, then 5 released under 9.
    s0 = strobes;
    set_keys(10'b0000100000);
    edges(8);
    chk("extra down", int'(bus.key_down), 1);
    chk("extra code", int'(bus.key_code), 5);
    set_keys(10'b1000100000);
    edges(4);
    chk("extra down both", int'(bus.key_down),  1);
    chk("extra err held",  int'(bus.multi_err), 0);
    set_keys(10'b1000000000);
    edges(10);
    chk("extra down 9 only", int'(bus.key_down), 1);
    chk("extra code 9 only", int'(bus.key_code), 5);
    set_keys('0);
    edges(8);
    chk("extra down final",   int'(bus.key_down), 0);
    chk("extra strobe count", strobes - s0, 1);

    // Digit 4 released and re-pressed during the release window.
    s0 = strobes;
    set_keys(10'b0000010000);
    edges(8);
    set_keys('0);
    edges(2);
    set_keys(10'b0000010000);
    edges(3);
    set_keys('0);
    edges(1);
    chk("repress down e6",  int'(bus.key_down), 1);
    edges(3);
    chk("repress down e9",  int'(bus.key_down), 1);
    edges(1);
    chk("repress down e10", int'(bus.key_down), 0);
    chk("repress code",     int'(bus.key_code), 4);
    chk("repress strobe count", strobes - s0, 1);
    edges(2);

    // Reset while digit 8 is held; it must be re-accepted afterwards.
    s0 = strobes;
    set_keys(10'b0100000000);
    edges(8);
    chk("rst pre down", int'(bus.key_down), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst async code",   int'(bus.key_code),   0);
    chk("rst async down",   int'(bus.key_down),   0);
    chk("rst async strobe", int'(bus.key_strobe), 0);
    chk("rst async err",    int'(bus.multi_err),  0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    edges(5);
    chk("rst strobe e5", int'(bus.key_strobe), 0);
    chk("rst down e5",   int'(bus.key_down),   0);
    edges(1);
    chk("rst strobe e6", int'(bus.key_strobe), 1);
    chk("rst code e6",   int'(bus.key_code),   8);
    chk("rst strobe count", strobes - s0, 2);
    set_keys('0);
    edges(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
